fabric_in_buf: RTL
==================

Name: fabric_in_buf

Overview:
- Per-direction input port buffer of a mini_core_tile, directly downstream of the fabric's in_<dir>_req / in_<dir>_req_valid wiring; one instance per cardinal input (N/E/S/W).
- Computes XY next-hop for each arriving t_tile_trans and stores it in one of five per-output-direction FIFOs.
- Produces the t_fab_ready vector returned to the upstream neighbour.
- Presents per-direction head entries to the tile's output arbiters.

Parameters:
DEPTH, 4, entries per direction FIFO; power of 2, >= 2
NUM_DIR, 5, output directions (N, E, S, W, LOCAL); fixed

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
local_tile_id  in  t_tile_id (8)  {col[3:0], row[3:0]} of this tile; static after reset
in_req_valid  in  1  upstream request valid
in_req  in  t_tile_trans  upstream transaction
in_ready  out  t_fab_ready (5)  bit d = FIFO for direction d can accept
out_req_valid  out  5  bit d = FIFO d non-empty
out_req  out  5 x t_tile_trans  head entry of FIFO d
out_pop  in  5  arbiter consumes head of FIFO d
overflow_err  out  1  sticky: push into full FIFO attempted

Behaviour:
- Direction encoding (ready and out_* index): NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4.
- Target tile id is in_req.address[31:24] = {tcol, trow}; local id = {lcol, lrow}.
- XY routing, column first:
  - tcol > lcol -> EAST; tcol < lcol -> WEST.
  - Else trow > lrow -> SOUTH; trow < lrow -> NORTH (rows increase downward).
  - Else LOCAL.
  - Purely combinational from in_req and local_tile_id.
- Push: in_req_valid=1 and in_ready[dir]=1 -> in_req written to FIFO dir at the clock edge.
- Latency: out_req_valid[dir]=1 and out_req[dir] valid from the next cycle. No same-cycle bypass.
- in_ready[d] = (count[d] != DEPTH), combinational from registered count only; no combinational path from in_req_valid or out_pop.
- Protocol violation: in_req_valid=1 with in_ready[dir]=0.
  - Transaction dropped; FIFO contents and count unchanged.
  - overflow_err set to 1 the next cycle; stays set until reset.
- Pop:
  - out_pop[d]=1 with count[d]>0 -> read pointer advances, count decrements.
  - out_pop[d]=1 with count[d]=0 -> ignored, no error.
- Simultaneous push and pop on the same d with 0<count<DEPTH: both occur, count unchanged, FIFO order preserved.
- Push at count=0 with out_pop[d]=1 the same cycle: pop ignored, push occurs.
- Pointer widths: log2(DEPTH); wrap naturally. Count width: log2(DEPTH)+1.
- The five FIFOs are independent; a full FIFO never blocks pushes to the others.
- Reset (async assert, sync-safe deassert handled at top level) forces:
  - all counts and pointers to 0
  - out_req_valid=5'b00000, in_ready=5'b11111, overflow_err=0
  - out_req contents don't-care
  - Applies immediately, including mid-traffic.

Decomposition:
- common_pkg additions:
  - t_cardinal enum (NORTH..LOCAL)
  - NUM_DIR constant
  - function xy_next_hop(t_tile_id local, t_tile_id target) returning t_cardinal
  - TILE_ID_MSB/LSB constants for the address slice
- Reuse the existing t_tile_trans, t_tile_id and t_fab_ready types.
- Sub-module fabric_fifo (parameterized DEPTH, data type t_tile_trans; push/pop/full/empty/count), instantiated NUM_DIR times via generate.

Test Plan:
- Reset -> in_ready=5'b11111, out_req_valid=5'b00000, overflow_err=0 without a clock edge.
- local_tile_id=8'h22; push targets 8'h32, 8'h12, 8'h21, 8'h23, 8'h22, 8'h31 one per cycle -> entries land in EAST, WEST, NORTH, SOUTH, LOCAL, EAST respectively; out_req_valid=5'b11111 after the sixth push, with EAST count=2.
- Four pushes to 8'h32, no pops -> in_ready=5'b11101 after the 4th edge; one out_pop[1] -> in_ready[1]=1 next cycle; head data matches the first push (FIFO order).
- EAST count=2; push 8'h33 and out_pop[1] in the same cycle -> count stays 2; pop order 2nd, 3rd entries.
- EAST full, push 8'h32 with valid=1 -> dropped; overflow_err=1 next cycle and sticky; EAST contents unchanged.
- Three entries across FIFOs; assert rst between clock edges -> out_req_valid=0 and in_ready=5'b11111 immediately; a post-reset push to 8'h22 -> out_req_valid=5'b10000 next cycle.

Source files
------------

// File: rtl/fabric_in_buf_pkg.sv
// Shared types and helpers for the fabric input buffer.
//   t_tile_id    : {col[3:0], row[3:0]} tile coordinate
//   t_tile_trans : fabric transaction (address carries the target tile id)
//   t_fab_ready  : per-direction ready vector returned upstream
//   t_cardinal   : output direction encoding (NORTH..LOCAL)
//   xy_next_hop  : column-first XY routing decision
package fabric_in_buf_pkg;

   localparam int unsigned NUM_DIR     = 5;
   localparam int unsigned TILE_ID_MSB = 31;
   localparam int unsigned TILE_ID_LSB = 24;

   typedef struct packed {
      logic [3:0] col;
      logic [3:0] row;
   } t_tile_id;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] data;
      logic        we;
   } t_tile_trans;

   typedef logic [NUM_DIR-1:0] t_fab_ready;

   typedef enum logic [2:0] {
      NORTH = 3'd0,
      EAST  = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } t_cardinal;

   // Column is resolved first; rows grow downward, so a larger target row
   // lies to the SOUTH.
   function automatic t_cardinal xy_next_hop(input t_tile_id local_id,
                                             input t_tile_id target);
      t_cardinal dir;
      if (target.col > local_id.col)
         dir = EAST;
      else if (target.col < local_id.col)
         dir = WEST;
      else if (target.row > local_id.row)
         dir = SOUTH;
      else if (target.row < local_id.row)
         dir = NORTH;
      else
         dir = LOCAL;
      return dir;
   endfunction

endpackage

// File: rtl/fabric_in_buf_fifo.sv
// fabric_fifo: single-direction transaction FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write data_in (ignored when full)
//   pop        : advance head (ignored when empty)
//   data_in    : transaction to store
//   data_out   : head transaction (valid when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module fabric_fifo
   import fabric_in_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  t_tile_trans              data_in,
   output t_tile_trans              data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   t_tile_trans        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data_in;
   end

   assign data_out = mem[rd_ptr];

endmodule

// File: rtl/fabric_in_buf.sv
// fabric_in_buf: per-input-port buffer of a tile. Routes each arriving
// transaction by XY next hop into one of NUM_DIR direction FIFOs.
//   clk, rst       : clock, asynchronous active-high reset
//   local_tile_id  : this tile's {col,row}, static after reset
//   in_req_valid   : upstream request valid
//   in_req         : upstream transaction
//   in_ready       : bit d = FIFO d can accept (from registered count only)
//   out_req_valid  : bit d = FIFO d non-empty
//   out_req        : head transaction of FIFO d
//   out_pop        : arbiter consumes head of FIFO d
//   overflow_err   : sticky, set after a push into a full FIFO
module fabric_in_buf
   import fabric_in_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  t_tile_id                          local_tile_id,
   input  logic                              in_req_valid,
   input  t_tile_trans                       in_req,
   output t_fab_ready                        in_ready,
   output logic        [NUM_DIR-1:0]         out_req_valid,
   output t_tile_trans [NUM_DIR-1:0]         out_req,
   input  logic        [NUM_DIR-1:0]         out_pop,
   output logic                              overflow_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   t_cardinal              route;
   logic [NUM_DIR-1:0]     push;
   logic [NUM_DIR-1:0]     full;
   logic [NUM_DIR-1:0]     empty;
   logic [CNT_W-1:0]       count [NUM_DIR];
   logic                   violation;

   assign route = xy_next_hop(local_tile_id,
                              t_tile_id'(in_req.address[TILE_ID_MSB:TILE_ID_LSB]));

   // A push to a full FIFO is offered but rejected inside the FIFO, so the
   // transaction is dropped and that FIFO's state is untouched.
   assign violation = in_req_valid && full[route];

   genvar d;
   generate
      for (d = 0; d < NUM_DIR; d++) begin : g_dir
         assign push[d] = in_req_valid && (route == t_cardinal'(d));

         fabric_fifo #(
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[d]),
            .pop      (out_pop[d]),
            .data_in  (in_req),
            .data_out (out_req[d]),
            .full     (full[d]),
            .empty    (empty[d]),
            .count    (count[d])
         );

         assign in_ready[d]      = (count[d] != CNT_W'(DEPTH));
         assign out_req_valid[d] = !empty[d];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_err <= 1'b0;
      else if (violation)
         overflow_err <= 1'b1;
   end

endmodule
